ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 149 ++++++++++++++
 tb/tb_ps2_frame_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Samples raw ps2clock/data in the Clk domain, assembles 11-bit frames,
// validates the stop bit (and optionally parity), and reports
// make/break scan codes.
// Optional feature macro: PS2_PARITY_CHECK_EN. When it is defined, a
// parity mismatch also rejects the frame.
//
// Output semantics: code_valid and frame_err are single-cycle strobes
// with no ready/back-pressure. A consumer must take scan_code/is_break
// in the cycle code_valid is high. Both values then hold until the next
// code_valid. The two strobes are never high together.
module ps2_frame_rx #(
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter logic [7:0]  BREAK_CODE     = 8'hF0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2clock,
    input  logic       data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam int         TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          stop_bit;
    logic          break_pending;

    logic          clk_s1, clk_s2, clk_hist;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic          parity_ok;
    logic          frame_ok;

    assign state_dbg = state;
    assign fall      = clk_hist & ~clk_s2;

    // Two-flop synchronizers plus ps2clock history. Reset to 1 = idle bus.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2clock;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            dat_s1   <= data;
            dat_s2   <= dat_s1;
        end
    end

    // Frame validity: stop bit must be 1. Parity (odd over data+parity) only when enabled.
    always_comb begin
        parity_ok = ^{shift_reg, parity_bit};
        frame_ok  = stop_bit & (parity_ok | ~PARITY_EN);
    end

    // Receive FSM, timeout supervision and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            to_cnt        <= '0;
            shift_reg     <= 8'h00;
            parity_bit    <= 1'b0;
            stop_bit      <= 1'b0;
            break_pending <= 1'b0;
            scan_code     <= 8'h00;
            is_break      <= 1'b0;
            code_valid    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= 4'd0;
                    to_cnt  <= '0;
                    // Only a start bit (data low) opens a frame.
                    if (fall && !dat_s2) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        to_cnt  <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            // LSB arrives first, so shift in from the top.
                            shift_reg <= {dat_s2, shift_reg[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            parity_bit <= dat_s2;
                        end else begin
                            stop_bit <= dat_s2;
                            state    <= CHECK;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Clock went quiet mid-frame: drop it.
                        frame_err     <= 1'b1;
                        break_pending <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (frame_ok) begin
                        if (shift_reg == BREAK_CODE) begin
                            break_pending <= 1'b1;
                        end else begin
                            scan_code     <= shift_reg;
                            is_break      <= break_pending;
                            code_valid    <= 1'b1;
                            break_pending <= 1'b0;
                        end
                    end else begin
                        frame_err     <= 1'b1;
                        break_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed bench for ps2_frame_rx with a strobe scoreboard.
// Honours PS2_PARITY_CHECK_EN the same way the design does.
module tb_ps2_frame_rx;

    localparam int HALF = 20;   // Clk cycles per PS/2 clock half-period
    localparam int TO   = 200;  // timeout used for this build

    logic       Clk;
    logic       Reset;
    logic       ps2clock;
    logic       data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       is_break;
    logic       frame_err;
    logic [1:0] state_dbg;

    // Expected entry: {is_err, is_break, scan_code}
    logic [9:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    logic prev_cv = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] last_scan;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TO),
        .BREAK_CODE    (8'hF0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ps2clock  (ps2clock),
        .data      (data),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .is_break  (is_break),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        @(negedge Clk);
        data = b;
        repeat (HALF) @(negedge Clk);
        ps2clock = 1'b0;
        repeat (HALF) @(negedge Clk);
        ps2clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stp);
        data = 1'b1;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic exp_push(input logic err, input logic brk, input logic [7:0] sc);
        exp_q.push_back({err, brk, sc});
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (!Reset) begin
            if (code_valid || frame_err) begin
                logic [9:0] e;
                checks++;
                if (code_valid && frame_err) begin
                    errors++;
                    $display("FAIL both_strobes: code_valid=1 frame_err=1 at %0t", $time);
                end else if ((code_valid && prev_cv) || (frame_err && prev_fe)) begin
                    errors++;
                    $display("FAIL strobe_width: strobe high two cycles, cv=%b fe=%b at %0t",
                             code_valid, frame_err, $time);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got err=%b brk=%b code=%h, none expected at %0t",
                             frame_err, is_break, scan_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({frame_err, is_break, scan_code} !== e) begin
                        errors++;
                        $display("FAIL strobe_value: got err=%b brk=%b code=%h expected err=%b brk=%b code=%h at %0t",
                                 frame_err, is_break, scan_code, e[9], e[8], e[7:0], $time);
                    end
                end
            end
            prev_cv <= code_valid;
            prev_fe <= frame_err;
        end else begin
            prev_cv <= 1'b0;
            prev_fe <= 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        Reset    = 1'b1;
        ps2clock = 1'b1;
        data     = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check8("rst_scan_code", scan_code, 8'h00);
        check8("rst_is_break", {7'd0, is_break}, 8'h00);
        check8("rst_code_valid", {7'd0, code_valid}, 8'h00);
        check8("rst_frame_err", {7'd0, frame_err}, 8'h00);

        // Stray fall with data high in IDLE must be ignored.
        send_bit(1'b1);
        repeat (HALF) @(negedge Clk);

        // Plain make code.
        exp_push(1'b0, 1'b0, 8'h1D);
        send_frame(8'h1D, 1'b1, 1'b1, HALF);

        // Break prefix then code, then a make code clears is_break.
        send_frame(8'hF0, 1'b1, 1'b1, HALF);
        exp_push(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, HALF);
        exp_push(1'b0, 1'b0, 8'h2D);
        send_frame(8'h2D, 1'b1, 1'b1, HALF);

        // 0x1B has four ones, so parity 0 is deliberately wrong.
`ifdef PS2_PARITY_CHECK_EN
        exp_push(1'b1, 1'b0, 8'h2D);
        last_scan = 8'h2D;
`else
        exp_push(1'b0, 1'b0, 8'h1B);
        last_scan = 8'h1B;
`endif
        send_frame(8'h1B, 1'b0, 1'b1, HALF);

        // Pending break then a bad stop bit: error, pending cleared.
        send_frame(8'hF0, 1'b1, 1'b1, HALF);
        exp_push(1'b1, 1'b0, last_scan);
        send_frame(8'h2D, 1'b1, 1'b0, HALF);
        exp_push(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, HALF);

        // Pending break then a truncated frame: timeout error.
        send_frame(8'hF0, 1'b1, 1'b1, HALF);
        exp_push(1'b1, 1'b0, 8'h1C);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge Clk);
        data = 1'b1;
        repeat (HALF) @(negedge Clk);
        ps2clock = 1'b0;
        cnt = 0;
        fork
            begin
                repeat (HALF) @(negedge Clk);
                ps2clock = 1'b1;
            end
            begin
                do begin
                    @(negedge Clk);
                    cnt++;
                end while (!frame_err && cnt < TO + 50);
            end
        join
        // 2 synchronizer cycles + 1 detect cycle + TO cycles.
        checks++;
        if (cnt != TO + 3) begin
            errors++;
            $display("FAIL timeout_latency: frame_err after %0d cycles expected %0d", cnt, TO + 3);
        end
        repeat (HALF) @(negedge Clk);
        exp_push(1'b0, 1'b0, 8'h2D);
        send_frame(8'h2D, 1'b1, 1'b1, HALF);

        // Back-to-back frames, no idle gap.
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        exp_push(1'b0, 1'b1, 8'h45);
        send_frame(8'h45, 1'b0, 1'b1, 0);
        exp_push(1'b0, 1'b0, 8'h16);
        send_frame(8'h16, 1'b0, 1'b1, HALF);
        exp_push(1'b0, 1'b0, 8'h3A);
        send_frame(8'h3A, 1'b1, 1'b1, HALF);

        // Break pending, then reset after 5 bits of a frame.
        send_frame(8'hF0, 1'b1, 1'b1, HALF);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check8("midrst_scan_code", scan_code, 8'h00);
        check8("midrst_is_break", {7'd0, is_break}, 8'h00);
        check8("midrst_code_valid", {7'd0, code_valid}, 8'h00);
        check8("midrst_frame_err", {7'd0, frame_err}, 8'h00);
        Reset = 1'b0;
        repeat (TO + 20) @(negedge Clk);
        exp_push(1'b0, 1'b0, 8'h1D);
        send_frame(8'h1D, 1'b1, 1'b1, HALF);

        repeat (50) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected strobes never seen, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
